// File: rtl/regfile_dump_pkg.sv
// Shared constants and state encoding for the register-file dump engine.
package regfile_dump_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks [start_addr, end_addr] over one async register-file read port and
// streams {addr, data, last} beats out over valid/ready.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] end_q;
    logic              load;
    logic              bad_range;

    // ptr is itself a flop, so the read address stays a registered output.
    assign rd_addr   = ptr;
    assign busy      = (state != IDLE);
    assign load      = (state == RUN) && (!out_valid || out_ready);
    assign bad_range = (start_addr > end_addr) || ({1'b0, end_addr} > MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            end_q     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_range) begin
                            err <= 1'b1;
                        end else begin
                            ptr   <= start_addr;
                            end_q <= end_addr;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        out_data  <= rd_data;
                        out_addr  <= ptr;
                        out_valid <= 1'b1;
                        out_last  <= (ptr == end_q);
                        // Stop on the last address so ptr can never wrap.
                        if (ptr == end_q) state <= DRAIN;
                        else              ptr   <= ptr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
